// File: rtl/mux_pkg.sv
// Shared definitions for the handshaked N-input multiplexer and its round-robin arbiter.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Cyclic successor of idx in 0..n-1.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_n_hs_rr_arbiter.sv
// Round-robin arbiter: cyclic priority search starting at ptr, ptr moves past the winner on advance.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [SEL_W-1:0] ptr;
    int unsigned      idx;

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!grant_vld && req[SEL_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && grant_vld) begin
            ptr <= SEL_W'(next_idx(int'(grant_idx), N_IN));
        end
    end

endmodule

// File: rtl/mux_n_hs.sv
// N-input registered multiplexer with valid/ready on every channel; direct-select or round-robin grant.
module mux_n_hs
    import mux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_IN   = 7,
    parameter int SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       selector,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]      data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       out_src
);

    localparam logic [SEL_W:0] N_IN_L = (SEL_W + 1)'(N_IN);

    logic [DATA_W-1:0] ch [N_IN];
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  dir_idx;
    logic [SEL_W-1:0]  g;
    logic              rr_vld;
    logic              granted;
    logic              can_accept;
    logic              transfer;
    logic              rr_advance;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            ch[i] = in_data[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter_n #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_valid),
        .advance   (rr_advance),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // Unused selector codes fold onto channel 0 so every code names exactly one channel.
    assign dir_idx    = ({1'b0, selector} < N_IN_L) ? selector : '0;
    assign g          = (mode == MODE_RR) ? rr_idx : dir_idx;
    assign granted    = (mode == MODE_RR) ? rr_vld : 1'b1;
    assign can_accept = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (can_accept && granted && !reset) begin
            in_ready[g] = 1'b1;
        end
    end

    assign transfer   = in_valid[g] && in_ready[g];
    assign rr_advance = transfer && (mode == MODE_RR);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (transfer) begin
            data_out  <= ch[g];
            out_src   <= g;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_hs.sv
// Directed stimulus for mux_n_hs; expected words queued at issue time and checked when the DUT hands them off.
module tb_mux_n_hs;

    localparam int DATA_W = 32;
    localparam int N_IN   = 7;
    localparam int SEL_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  src;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   mode;
    logic [SEL_W-1:0]       selector;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN-1:0]        in_ready;
    logic [DATA_W-1:0]      data_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [SEL_W-1:0]       out_src;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mux_n_hs #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .selector  (selector),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    function automatic logic [DATA_W-1:0] ch_word(input int i);
        return 32'hA5A5_0000 | DATA_W'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One cycle: apply inputs after the edge, check in_ready mid-cycle, queue the word that will transfer.
    task automatic drive(input logic rst, input logic m, input logic [SEL_W-1:0] s,
                         input logic [N_IN-1:0] v, input logic r,
                         input logic [N_IN-1:0] exp_rdy, input string name);
        @(posedge clk);
        #1;
        reset     = rst;
        mode      = m;
        selector  = s;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        chk(name, 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < N_IN; i++) begin
            if (exp_rdy[i] && v[i]) begin
                exp_q.push_back('{data: ch_word(i), src: SEL_W'(i)});
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got src %0d data %0h, expected no word", out_src, data_out);
            end else begin
                e = exp_q.pop_front();
                chk("mon_data", 64'(data_out), 64'(e.data));
                chk("mon_src", 64'(out_src), 64'(e.src));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        selector  = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            in_data[i*DATA_W +: DATA_W] = ch_word(i);
        end

        // Reset: in_ready gated even though direct mode would grant ch0.
        drive(1'b1, 1'b0, 3'd0, 7'h00, 1'b1, 7'b0000000, "rst_in_ready");
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);

        // Direct mode.
        drive(1'b0, 1'b0, 3'd5, 7'b0100000, 1'b1, 7'b0100000, "direct_sel5_rdy");
        drive(1'b0, 1'b0, 3'd6, 7'b1000000, 1'b1, 7'b1000000, "direct_sel6_rdy");
        drive(1'b0, 1'b0, 3'd7, 7'h7F,      1'b1, 7'b0000001, "direct_sel7_rdy");
        drive(1'b0, 1'b0, 3'd0, 7'h00,      1'b1, 7'b0000001, "direct_idle_rdy");

        // Round-robin fairness over channels 1, 4, 6.
        drive(1'b0, 1'b1, 3'd0, 7'b1010010, 1'b1, 7'b0000010, "rr_1a");
        drive(1'b0, 1'b1, 3'd0, 7'b1010010, 1'b1, 7'b0010000, "rr_4a");
        chk("rr_ptr_after_first", 64'(dut.u_arb.ptr), 64'd2);
        drive(1'b0, 1'b1, 3'd0, 7'b1010010, 1'b1, 7'b1000000, "rr_6a");
        drive(1'b0, 1'b1, 3'd0, 7'b1010010, 1'b1, 7'b0000010, "rr_1b");
        drive(1'b0, 1'b1, 3'd0, 7'b1010010, 1'b1, 7'b0010000, "rr_4b");
        drive(1'b0, 1'b1, 3'd0, 7'b1010010, 1'b1, 7'b1000000, "rr_6b");

        // Backpressure with ch6 held.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 3'd0, 7'h7F, 1'b0, 7'b0000000, "bp_stall_rdy");
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(data_out), 64'(ch_word(6)));
            chk("bp_hold_src", 64'(out_src), 64'd6);
        end
        drive(1'b0, 1'b1, 3'd0, 7'h7F, 1'b1, 7'b0000001, "bp_release_rdy");
        drive(1'b0, 1'b1, 3'd0, 7'h7F, 1'b0, 7'b0000000, "bp_after_rdy");
        chk("bp_no_bubble_valid", 64'(out_valid), 64'd1);
        chk("bp_new_data", 64'(data_out), 64'(ch_word(0)));
        chk("bp_new_src", 64'(out_src), 64'd0);

        // Reset mid-stall: held ch0 word is dropped, ptr (was 1) returns to 0.
        drive(1'b1, 1'b1, 3'd0, 7'h7F, 1'b0, 7'b0000000, "rst_stall_rdy");
        chk("rst_stall_still_valid", 64'(out_valid), 64'd1);
        exp_q.delete();
        drive(1'b0, 1'b1, 3'd0, 7'h7F, 1'b1, 7'b0000001, "rr_after_rst_rdy");
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_data", 64'(data_out), 64'd0);
        chk("rst_stall_src", 64'(out_src), 64'd0);

        // Mode switch: RR from ch3 leaves ptr=4, direct transfers do not move it.
        drive(1'b0, 1'b1, 3'd0, 7'b0001000, 1'b1, 7'b0001000, "ms_rr3_rdy");
        drive(1'b0, 1'b0, 3'd0, 7'h7F,      1'b1, 7'b0000001, "ms_dir0a_rdy");
        drive(1'b0, 1'b0, 3'd0, 7'h7F,      1'b1, 7'b0000001, "ms_dir0b_rdy");
        drive(1'b0, 1'b1, 3'd0, 7'h7F,      1'b1, 7'b0010000, "ms_rr4_rdy");

        // Drain: out_valid drops, last word and source stay.
        drive(1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 7'b0000001, "drain_rdy");
        drive(1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 7'b0000001, "idle_rdy");
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_data", 64'(data_out), 64'(ch_word(4)));
        chk("drain_src", 64'(out_src), 64'd4);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_n_hs.md
Name: mux_n_hs

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Successor to the fixed 7x32 combinational datapath mux.
- Two modes:
  - direct: an explicit selector chooses the channel.
  - round-robin: fair arbitration among valid inputs.
- Used where several producers (ALU, shifter, memory data register, exception vector) share one consumer register across multicycle states.

Parameters:
- DATA_W, 32, data width of each channel.
- N_IN, 7, number of input channels, minimum 2.
- SEL_W, $clog2(N_IN), width of selector and source-index fields.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = direct select, 1 = round-robin.
- selector  in  SEL_W  channel index used in direct mode.
- in_data  in  N_IN*DATA_W  flattened inputs; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready, one-hot or zero.
- data_out  out  DATA_W  registered output word.
- out_valid  out  1  data_out holds an unconsumed word.
- out_ready  in  1  consumer accepts data_out this cycle.
- out_src  out  SEL_W  channel index that produced data_out.

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the rising clk edge.
  - data_out=0, out_valid=0, out_src=0, round-robin pointer ptr=0.
  - A held word is discarded.
  - in_ready is all-zero while reset is high.
- can_accept = !out_valid || out_ready (single output register, full throughput).
- Grant g, combinational:
  - Direct mode: g = selector when selector < N_IN; otherwise g = 0. Every code maps to exactly one channel; there are no duplicate or missing cases.
  - Round-robin mode: g = first index i with in_valid[i]=1, searching cyclically from ptr upward with wrap N_IN-1 -> 0. No valid input means no grant.
- in_ready[i] = can_accept && granted && (i == g) && !reset.
  - In direct mode, in_ready[g] may assert with in_valid[g]=0. No transfer occurs in that case.
- Transfer: a transfer occurs on an edge where in_valid[g] && in_ready[g]. On that edge:
  - data_out <= channel g
  - out_src <= g
  - out_valid <= 1
- Latency: one cycle from input transfer to out_valid.
- Output drain: out_valid && out_ready with no new transfer clears out_valid. data_out and out_src keep their last value.
- Simultaneous drain and transfer: out_valid stays 1 and the new word replaces the old one in the same edge, with no bubble.
- Stall: while out_valid && !out_ready, data_out and out_src are held stable and in_ready is all-zero.
- Pointer update:
  - Only on a round-robin-mode transfer: ptr <= (g == N_IN-1) ? 0 : g+1.
  - Direct-mode transfers leave ptr unchanged.
  - A mode change preserves ptr and takes effect from the next grant evaluation.
- Input stability: inputs are not required to hold a valid that was not granted; the block imposes no ordering beyond arbitration.
- Reset mid-stall: the word is dropped and out_valid is 0 on the next cycle.

Decomposition:
- Shared package mux_pkg:
  - MODE_DIRECT = 1'b0 and MODE_RR = 1'b1.
  - A helper function for the cyclic next index.
- Sub-module rr_arbiter_n:
  - Parameters N_IN and SEL_W.
  - Ports: clk, reset, req[N_IN], advance, grant_idx, grant_vld.
  - Owns ptr and the cyclic priority search.
- The top level holds the direct/RR grant select, the ready generation and the output register.

Test Plan:
1. Direct basic: N_IN=7, DATA_W=32, mode=0, selector=5, in_valid[5]=1, in_data ch5=32'hA5A5_0005, out_ready=1 -> in_ready=7'b0100000; next cycle data_out=32'hA5A5_0005, out_valid=1, out_src=5. Repeat with selector=6 -> channel 6 word (distinct from ch5).
2. Out-of-range selector: selector=7, in_valid=7'h7F -> in_ready=7'b0000001; data_out = ch0 word, out_src=0.
3. Round-robin fairness: mode=1, in_valid=7'b1010010 held, out_ready=1 -> out_src sequence 1,4,6,1,4,6; ptr after first transfer = 2.
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid all 1 -> in_ready=0 and data_out/out_src constant. Then out_ready=1 -> new word loaded the same edge and out_valid stays 1 (no bubble).
5. Reset mid-stall: out_valid=1, out_ready=0, reset=1 for one cycle -> next cycle out_valid=0, data_out=0, out_src=0; ptr=0 (next RR grant is the lowest valid index).
6. Mode switch: RR transfer from ch3 (ptr=4), then direct transfers with selector=0 twice, then mode=1 with in_valid=7'h7F -> first RR grant is ch4.
